// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Raster timing source. Produces signed hpos/vpos coordinates
//                (blanking is the negative range), hsync/vsync, data-enable,
//                line/frame strobes and a free-running frame counter. All
//                outputs are registered and mutually aligned.
//  Revision    : 1.0  initial release
// ============================================================================
module video_timing_gen #(
  parameter int   HRES   = 1280,
  parameter int   VRES   = 720,
  parameter int   H_FP   = 110,
  parameter int   H_SYNC = 40,
  parameter int   H_BP   = 220,
  parameter int   V_FP   = 5,
  parameter int   V_SYNC = 5,
  parameter int   V_BP   = 20,
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               rst,
  output logic signed [11:0] hpos,
  output logic signed [11:0] vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               fsync,
  output logic               lsync,
  output logic [15:0]        frame_cnt
);

  // --------------------------------------------------------------------------
  // Derived timing constants. The blanking interval occupies the negative
  // coordinates, ordered front porch, sync, back porch, then active video.
  // --------------------------------------------------------------------------
  localparam int C_H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int C_V_BLANK = V_FP + V_SYNC + V_BP;

  localparam logic signed [11:0] C_H_START   = 12'(-C_H_BLANK);
  localparam logic signed [11:0] C_V_START   = 12'(-C_V_BLANK);
  localparam logic signed [11:0] C_H_LAST    = 12'(HRES - 1);
  localparam logic signed [11:0] C_V_LAST    = 12'(VRES - 1);
  localparam logic signed [11:0] C_HS_FIRST  = 12'(-C_H_BLANK + H_FP);
  localparam logic signed [11:0] C_HS_LAST   = 12'(-C_H_BLANK + H_FP + H_SYNC - 1);
  localparam logic signed [11:0] C_VS_FIRST  = 12'(-C_V_BLANK + V_FP);
  localparam logic signed [11:0] C_VS_LAST   = 12'(-C_V_BLANK + V_FP + V_SYNC - 1);
  localparam logic signed [11:0] C_ONE       = 12'sd1;
  localparam logic signed [11:0] C_ZERO      = 12'sd0;

  // --------------------------------------------------------------------------
  // Elaboration-time range checks: both coordinate ranges must fit a 12-bit
  // signed value, otherwise the wrap points would alias.
  // --------------------------------------------------------------------------
  generate
    if ((HRES - 1) > 2047 || HRES < 1) begin : g_bad_hres
      $error("video_timing_gen: HRES out of 12-bit signed range");
    end
    if (C_H_BLANK > 2048 || C_H_BLANK < 1) begin : g_bad_hblank
      $error("video_timing_gen: horizontal blanking out of 12-bit signed range");
    end
    if ((VRES - 1) > 2047 || VRES < 1) begin : g_bad_vres
      $error("video_timing_gen: VRES out of 12-bit signed range");
    end
    if (C_V_BLANK > 2048 || C_V_BLANK < 1) begin : g_bad_vblank
      $error("video_timing_gen: vertical blanking out of 12-bit signed range");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State registers and their next-state values
  // --------------------------------------------------------------------------
  logic signed [11:0] hpos_q,  hpos_d;
  logic signed [11:0] vpos_q,  vpos_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q,    de_d;
  logic               fsync_q, fsync_d;
  logic               lsync_q, lsync_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               h_wrap;
  logic               hs_active;
  logic               vs_active;

  // Next-state coordinates: hpos steps every cycle, vpos only on the line wrap.
  always_comb begin
    h_wrap = (hpos_q == C_H_LAST);
    hpos_d = h_wrap ? C_H_START : (hpos_q + C_ONE);
    vpos_d = vpos_q;
    if (h_wrap) begin
      vpos_d = (vpos_q == C_V_LAST) ? C_V_START : (vpos_q + C_ONE);
    end
  end

  // Decode syncs, enable and strobes from the next-state coordinates so the
  // registered versions line up with the registered hpos/vpos.
  always_comb begin
    hs_active   = (hpos_d >= C_HS_FIRST) && (hpos_d <= C_HS_LAST);
    vs_active   = (vpos_d >= C_VS_FIRST) && (vpos_d <= C_VS_LAST);
    hsync_d     = hs_active ? HS_POL : ~HS_POL;
    vsync_d     = vs_active ? VS_POL : ~VS_POL;
    de_d        = (hpos_d >= C_ZERO) && (vpos_d >= C_ZERO);
    lsync_d     = (hpos_d == C_H_START);
    fsync_d     = (hpos_d == C_H_START) && (vpos_d == C_V_START);
    frame_cnt_d = fsync_d ? (frame_cnt_q + 16'd1) : frame_cnt_q;
  end

  // Output registers; reset parks the raster at the first blanking pixel
  // without announcing a frame or line start.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hpos_q      <= C_H_START;
      vpos_q      <= C_V_START;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      de_q        <= 1'b0;
      fsync_q     <= 1'b0;
      lsync_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      fsync_q     <= fsync_d;
      lsync_q     <= lsync_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hpos      = hpos_q;
  assign vpos      = vpos_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign fsync     = fsync_q;
  assign lsync     = lsync_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire
